// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter in front of the SDRAM controller user port.
// Ports: clock/reset, r0_*/r1_* requester ports, mc_* controller port, idle, err.
module mem_port_arbiter #(
  parameter int MAX_RD = 4,
  parameter int AW     = 22,
  parameter int DW     = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic [DW-1:0] r0_rdata,
  output logic          r0_rvalid,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic [DW-1:0] r1_rdata,
  output logic          r1_rvalid,
  input  logic          mc_ready,
  output logic          mc_we,
  output logic          mc_re,
  output logic [AW-1:0] mc_addr,
  output logic [DW-1:0] mc_data_in,
  input  logic [DW-1:0] mc_data_out,
  input  logic          mc_data_out_valid,
  output logic          idle,
  output logic          err
);

  localparam int PW = $clog2(MAX_RD);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_RD);

  logic          ptr_q;
  logic          tag_q [MAX_RD];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          rv0_q;
  logic          rv1_q;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;
  logic          err_q;

  logic full;
  logic empty;
  logic elig0;
  logic elig1;
  logic issue;
  logic win;
  logic win_we;
  logic push;
  logic pop;
  logic head;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);

  // A full tag FIFO masks reads only, so a blocked read never wins a turn.
  assign elig0 = r0_req & (r0_we | ~full);
  assign elig1 = r1_req & (r1_we | ~full);

  assign issue  = ~reset & mc_ready & (elig0 | elig1);
  assign win    = (elig0 & elig1) ? ptr_q : elig1;
  assign win_we = win ? r1_we : r0_we;

  assign r0_gnt = issue & ~win;
  assign r1_gnt = issue & win;
  assign mc_we  = issue & win_we;
  assign mc_re  = issue & ~win_we;

  assign mc_addr    = (issue & win) ? r1_addr  : r0_addr;
  assign mc_data_in = (issue & win) ? r1_wdata : r0_wdata;

  assign push = mc_re;
  assign pop  = mc_data_out_valid & ~empty;
  assign head = tag_q[rd_q];

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q    <= 1'b0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      rv0_q    <= 1'b0;
      rv1_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < MAX_RD; i++) tag_q[i] <= 1'b0;
    end else begin
      if (issue) ptr_q <= ~win;
      if (push) begin
        tag_q[wr_q] <= win;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      rv0_q <= pop & ~head;
      rv1_q <= pop & head;
      if (pop & ~head) rdata0_q <= mc_data_out;
      if (pop & head)  rdata1_q <= mc_data_out;
      // Returns with no outstanding tag are dropped and flagged.
      if (mc_data_out_valid & empty) err_q <= 1'b1;
    end
  end

  assign r0_rvalid = rv0_q;
  assign r1_rvalid = rv1_q;
  assign r0_rdata  = rdata0_q;
  assign r1_rdata  = rdata1_q;
  assign idle      = empty;
  assign err       = err_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single user-side port of the SDRAM memory controller between two requesters, e.g. the hardware testbench and a future DMA/scrubber engine.
- Arbitrates round-robin and issues one command per cycle when the controller is ready.
- Tracks outstanding reads in an in-order tag FIFO so each returned read word is steered to the requester that issued it.

Parameters:
MAX_RD, 4, maximum outstanding reads (tag FIFO depth; power of 2, >=2)
AW, 22, address width
DW, 16, data width

Ports:
clock  in  1  system clock (133 MHz domain)
reset  in  1  synchronous, active-high reset
r0_req, r1_req  in  1  request pending; held with its fields stable until granted
r0_we, r1_we  in  1  1=write, 0=read
r0_addr, r1_addr  in  AW  word address
r0_wdata, r1_wdata  in  DW  write data
r0_gnt, r1_gnt  out  1  one-cycle pulse: request accepted this cycle
r0_rdata, r1_rdata  out  DW  read return data
r0_rvalid, r1_rvalid  out  1  one-cycle pulse: rN_rdata valid
mc_ready  in  1  controller accepts a command this cycle
mc_we, mc_re  out  1  command strobes to controller
mc_addr  out  AW  command address
mc_data_in  out  DW  write data to controller
mc_data_out  in  DW  read data from controller
mc_data_out_valid  in  1  read data valid
idle  out  1  no outstanding reads (tag FIFO empty)
err  out  1  sticky: read return arrived with no outstanding tag

Behaviour:
- Reset (synchronous, active-high, sampled on the clock edge):
  - clears the priority pointer (requester 0 favoured), tag FIFO, err, rdata and rvalid.
  - During reset, gnt, mc_we and mc_re are 0.
- Eligibility: rN is eligible when rN_req=1 and (rN_we=1 or tag FIFO not full).
- Issue is combinational in cycle t, when mc_ready=1 and at least one requester is eligible:
  - Winner = the only eligible requester; if both are eligible, the one selected by the priority pointer.
  - rWIN_gnt=1.
  - mc_we = rWIN_we, mc_re = ~rWIN_we.
  - mc_addr and mc_data_in are driven from the winner.
  - mc_we and mc_re are never both 1, and are never 1 when mc_ready=0.
- When nothing is issued: mc_addr and mc_data_in are driven from requester 0; strobes are 0.
- Priority pointer: after any grant it points to the non-winning requester. It is unchanged on cycles with no grant.
- Read issue pushes the winner ID into the tag FIFO at the edge ending cycle t.
- Read return:
  - On mc_data_out_valid=1 with the FIFO non-empty: pop the head ID H. In cycle t+1, rH_rvalid=1 and rH_rdata = the mc_data_out captured at t. The other rvalid is 0.
  - rdata for a non-addressed requester holds its last value.
- Simultaneous push and pop in one cycle: both take effect; count unchanged. A push when full cannot occur, because eligibility masks it.
- Orphan return (mc_data_out_valid=1, FIFO empty): data dropped, no rvalid, err set to 1 until reset.
- Returns after a mid-operation reset are orphans and follow the orphan rule above.
- Blocking rules:
  - Full FIFO blocks only reads; a write from either requester still issues.
  - A blocked read does not consume the priority turn.
- idle = (FIFO count == 0), combinational from state.
- Fairness: two continuously eligible requesters alternate grants every ready cycle.
- Throughput: one command per ready cycle; no bubbles are added by the arbiter.

Test Plan:
- Single read: r0 reads addr 0x000010, controller returns 0xBEEF 5 cycles after issue -> r0_gnt pulses in the issue cycle; r0_rvalid=1 with r0_rdata=0xBEEF one cycle after the return; r1_rvalid stays 0; idle goes 0 then back to 1.
- Contention: both request writes continuously with mc_ready=1 for 6 cycles after reset -> grant order r0,r1,r0,r1,r0,r1; mc_data_in matches the granted requester each cycle.
- Interleaved reads: r1 read 0x3FFFFF, then r0 read 0x000001, returns 0x1111 then 0x2222 -> r1 gets 0x1111, r0 gets 0x2222, in order.
- FIFO full: 4 reads are outstanding, r0 requests a read and r1 a write -> r1 granted; r0 is not granted until a return arrives. In that return cycle r0 is not yet eligible (push and pop in one cycle is not exercised here); r0 is granted on the cycle after the return pops the FIFO.
- Ready low: requests held with mc_ready=0 for 3 cycles -> no gnt, mc_we=mc_re=0; the grant happens on the first mc_ready=1 cycle.
- Reset mid-operation: 2 reads outstanding, reset asserted for 1 cycle, then 2 returns arrive -> no rvalid, err=1, idle=1.
